// File: rtl/serial_cmd_engine_if.sv
// -----------------------------------------------------------------------------
// serial_cmd_engine_if
// Byte-level handshake between the UART rx/tx pair and serial_cmd_engine.
//   rx_ready : one-cycle strobe, rx_data valid         (UART -> engine)
//   rx_data  : received byte                           (UART -> engine)
//   tx_busy  : transmitter busy                        (UART -> engine)
//   tx_start : one-cycle strobe, tx_data valid         (engine -> UART)
//   tx_data  : byte to transmit                        (engine -> UART)
// The engine uses the slave modport; the UART side (or a bench) uses master.
// -----------------------------------------------------------------------------
interface serial_cmd_engine_if;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       tx_busy;
    logic       tx_start;
    logic [7:0] tx_data;

    modport master (output rx_ready, rx_data, tx_busy, input tx_start, tx_data);
    modport slave  (input rx_ready, rx_data, tx_busy, output tx_start, tx_data);
endinterface

// File: rtl/serial_cmd_engine.sv
// -----------------------------------------------------------------------------
// serial_cmd_engine
// Byte-serial command processor between the UART and the trigger fabric.
// Decodes single-byte commands (with 0..2 argument bytes), drives config
// registers, PLL dynamic-phase and clock-switch controls, and streams
// snapshot responses back through the UART.
//
// Ports:
//   clk, reset          : system clock, asynchronous active-high reset
//   uart                : rx/tx byte handshake (serial_cmd_engine_if.slave)
//   last_cmd            : most recent command byte
//   deadticks           : dead-time config
//   histotosend         : histogram select config
//   enable_outputs      : output-enable toggle (low enables outputs)
//   phasecounterselect  : PLL counter select
//   phaseupdown         : PLL phase direction (1 = up)
//   phasestep, scanclk  : PLL dynamic phase stepping
//   clkswitch           : PLL clock-switch request
//   histos, resethist   : histogram counts in, one-cycle clear out
//   delaycounter        : delay counter bytes in
//   activeclock         : PLL active-clock indicator
//   busy                : engine not idle
//   err_count           : saturating error counter
//
// state   | meaning
// IDLE    | waiting for a command byte
// ARGS    | collecting argument bytes, argument timeout running
// EXEC    | one-cycle command execution
// TX_WAIT | waiting for transmitter idle, then launch one byte
// TX_HOLD | one spacing cycle after each launched byte
// PHASE   | running N PLL phase steps (8 scanclk toggles each)
// CLKSW   | holding clkswitch high
// -----------------------------------------------------------------------------
module serial_cmd_engine #(
    parameter int unsigned FW_VERSION       = 4,
    parameter int unsigned NHISTO           = 8,
    parameter int unsigned HISTO_WIDTH      = 32,
    parameter int unsigned NDELAY           = 16,
    parameter int unsigned ARG_TIMEOUT      = 50000000,
    parameter int unsigned SCAN_DIV         = 16,
    parameter int unsigned CLKSWITCH_CYCLES = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    serial_cmd_engine_if.slave            uart,
    output logic [7:0]                    last_cmd,
    output logic [7:0]                    deadticks,
    output logic [7:0]                    histotosend,
    output logic                          enable_outputs,
    output logic [2:0]                    phasecounterselect,
    output logic                          phaseupdown,
    output logic                          phasestep,
    output logic                          scanclk,
    output logic                          clkswitch,
    input  logic [NHISTO*HISTO_WIDTH-1:0] histos,
    output logic                          resethist,
    input  logic [NDELAY*8-1:0]           delaycounter,
    input  logic                          activeclock,
    output logic                          busy,
    output logic [7:0]                    err_count
);

    localparam int unsigned HB        = NHISTO * HISTO_WIDTH / 8;
    localparam int unsigned BUF_BYTES = (HB > NDELAY) ? HB : NDELAY;
    localparam int unsigned IW        = $clog2(BUF_BYTES + 1);
    localparam int unsigned TW        = $clog2(ARG_TIMEOUT + 1);
    localparam int unsigned DW        = $clog2(SCAN_DIV + 1);
    localparam int unsigned CW        = $clog2(CLKSWITCH_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE, ARGS, EXEC, TX_WAIT, TX_HOLD, PHASE, CLKSW
    } state_t;

    function automatic logic [1:0] args_needed(input logic [7:0] c);
        case (c)
            8'd1, 8'd2: return 2'd1;
            8'd5:       return 2'd2;
            default:    return 2'd0;
        endcase
    endfunction

    state_t               state_q, state_d;
    logic [7:0]           last_cmd_q, last_cmd_d;
    logic [7:0]           arg0_q, arg0_d, arg1_q, arg1_d;
    logic [1:0]           arg_cnt_q, arg_cnt_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [7:0]           err_count_q, err_count_d;
    logic [7:0]           deadticks_q, deadticks_d;
    logic [7:0]           histotosend_q, histotosend_d;
    logic                 enable_outputs_q, enable_outputs_d;
    logic [2:0]           phasecounterselect_q, phasecounterselect_d;
    logic                 phaseupdown_q, phaseupdown_d;
    logic                 phasestep_q, phasestep_d;
    logic                 scanclk_q, scanclk_d;
    logic                 clkswitch_q, clkswitch_d;
    logic                 resethist_q, resethist_d;
    logic                 tx_start_q, tx_start_d;
    logic [7:0]           tx_data_q, tx_data_d;
    logic [BUF_BYTES*8-1:0] buf_q, buf_d;
    logic [IW-1:0]        tx_len_q, tx_len_d;
    logic [IW-1:0]        tx_idx_q, tx_idx_d;
    logic [7:0]           steps_q, steps_d;
    logic [DW-1:0]        div_q, div_d;
    logic [3:0]           tog_q, tog_d;
    logic [CW-1:0]        cs_cnt_q, cs_cnt_d;
    logic [1:0]           err_inc;
    logic [8:0]           err_sum;

    always_comb begin
        state_d              = state_q;
        last_cmd_d           = last_cmd_q;
        arg0_d               = arg0_q;
        arg1_d               = arg1_q;
        arg_cnt_d            = arg_cnt_q;
        timer_d              = timer_q;
        deadticks_d          = deadticks_q;
        histotosend_d        = histotosend_q;
        enable_outputs_d     = enable_outputs_q;
        phasecounterselect_d = phasecounterselect_q;
        phaseupdown_d        = phaseupdown_q;
        phasestep_d          = phasestep_q;
        scanclk_d            = scanclk_q;
        clkswitch_d          = clkswitch_q;
        resethist_d          = 1'b0;
        tx_start_d           = 1'b0;
        tx_data_d            = tx_data_q;
        buf_d                = buf_q;
        tx_len_d             = tx_len_q;
        tx_idx_d             = tx_idx_q;
        steps_d              = steps_q;
        div_d                = div_q;
        tog_d                = tog_q;
        cs_cnt_d             = cs_cnt_q;
        err_inc              = 2'd0;

        case (state_q)
            IDLE: begin
                if (uart.rx_ready) begin
                    last_cmd_d = uart.rx_data;
                    arg_cnt_d  = 2'd0;
                    timer_d    = TW'(ARG_TIMEOUT - 1);
                    state_d    = (args_needed(uart.rx_data) != 2'd0) ? ARGS : EXEC;
                end
            end

            ARGS: begin
                // A byte arriving on the terminal-count cycle still counts.
                if (uart.rx_ready) begin
                    if (arg_cnt_q == 2'd0) arg0_d = uart.rx_data;
                    else                   arg1_d = uart.rx_data;
                    arg_cnt_d = arg_cnt_q + 2'd1;
                    timer_d   = TW'(ARG_TIMEOUT - 1);
                    if (arg_cnt_q + 2'd1 == args_needed(last_cmd_q)) state_d = EXEC;
                end else if (timer_q == '0) begin
                    err_inc = err_inc + 2'd1;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end

            EXEC: begin
                state_d  = IDLE;
                tx_idx_d = '0;
                case (last_cmd_q)
                    8'd0: begin
                        buf_d      = '0;
                        buf_d[7:0] = 8'(FW_VERSION);
                        tx_len_d   = IW'(1);
                        state_d    = TX_WAIT;
                    end
                    8'd1: deadticks_d      = arg0_q;
                    8'd2: histotosend_d    = arg0_q;
                    8'd3: enable_outputs_d = ~enable_outputs_q;
                    8'd4: begin
                        clkswitch_d = 1'b1;
                        cs_cnt_d    = CW'(CLKSWITCH_CYCLES - 1);
                        state_d     = CLKSW;
                    end
                    8'd5: begin
                        phasecounterselect_d = arg0_q[2:0];
                        phaseupdown_d        = arg0_q[7];
                        steps_d              = (arg1_q == 8'd0) ? 8'd1 : arg1_q;
                        div_d                = DW'(SCAN_DIV - 1);
                        tog_d                = 4'd0;
                        phasestep_d          = 1'b1;
                        scanclk_d            = 1'b0;
                        state_d              = PHASE;
                    end
                    8'd8: begin
                        buf_d      = '0;
                        buf_d[7:0] = {7'b0, activeclock};
                        tx_len_d   = IW'(1);
                        state_d    = TX_WAIT;
                    end
                    8'd9: phaseupdown_d = ~phaseupdown_q;
                    8'd10: begin
                        buf_d             = '0;
                        buf_d[HB*8-1:0]   = histos;
                        tx_len_d          = IW'(HB);
                        resethist_d       = 1'b1;
                        state_d           = TX_WAIT;
                    end
                    8'd11: begin
                        buf_d                 = '0;
                        buf_d[NDELAY*8-1:0]   = delaycounter;
                        tx_len_d              = IW'(NDELAY);
                        state_d               = TX_WAIT;
                    end
                    8'd13: begin
                        buf_d      = '0;
                        buf_d[7:0] = err_count_q;
                        tx_len_d   = IW'(1);
                        state_d    = TX_WAIT;
                    end
                    default: err_inc = err_inc + 2'd1;
                endcase
            end

            TX_WAIT: begin
                if (!uart.tx_busy) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = 8'(buf_q >> {tx_idx_q, 3'b000});
                    tx_idx_d   = tx_idx_q + IW'(1);
                    state_d    = TX_HOLD;
                end
            end

            TX_HOLD: state_d = (tx_idx_q == tx_len_q) ? IDLE : TX_WAIT;

            PHASE: begin
                if (div_q == '0) begin
                    div_d     = DW'(SCAN_DIV - 1);
                    scanclk_d = ~scanclk_q;
                    tog_d     = tog_q + 4'd1;
                    if (tog_q == 4'd5) phasestep_d = 1'b0;
                    if (tog_q == 4'd7) begin
                        // 8th toggle closes the step; the next step starts on the same edge.
                        tog_d     = 4'd0;
                        scanclk_d = 1'b0;
                        if (steps_q == 8'd1) begin
                            state_d = IDLE;
                        end else begin
                            steps_d     = steps_q - 8'd1;
                            phasestep_d = 1'b1;
                        end
                    end
                end else begin
                    div_d = div_q - DW'(1);
                end
            end

            CLKSW: begin
                if (cs_cnt_q == '0) begin
                    clkswitch_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    cs_cnt_d = cs_cnt_q - CW'(1);
                end
            end

            default: state_d = IDLE;
        endcase

        if (uart.rx_ready && (state_q inside {EXEC, TX_WAIT, TX_HOLD, PHASE, CLKSW}))
            err_inc = err_inc + 2'd1;

        err_sum     = {1'b0, err_count_q} + {7'b0, err_inc};
        err_count_d = err_sum[8] ? 8'hFF : err_sum[7:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q              <= IDLE;
            last_cmd_q           <= '0;
            arg0_q               <= '0;
            arg1_q               <= '0;
            arg_cnt_q            <= '0;
            timer_q              <= '0;
            err_count_q          <= '0;
            deadticks_q          <= '0;
            histotosend_q        <= '0;
            enable_outputs_q     <= 1'b0;
            phasecounterselect_q <= '0;
            phaseupdown_q        <= 1'b1;
            phasestep_q          <= 1'b0;
            scanclk_q            <= 1'b0;
            clkswitch_q          <= 1'b0;
            resethist_q          <= 1'b0;
            tx_start_q           <= 1'b0;
            tx_data_q            <= '0;
            buf_q                <= '0;
            tx_len_q             <= '0;
            tx_idx_q             <= '0;
            steps_q              <= '0;
            div_q                <= '0;
            tog_q                <= '0;
            cs_cnt_q             <= '0;
        end else begin
            state_q              <= state_d;
            last_cmd_q           <= last_cmd_d;
            arg0_q               <= arg0_d;
            arg1_q               <= arg1_d;
            arg_cnt_q            <= arg_cnt_d;
            timer_q              <= timer_d;
            err_count_q          <= err_count_d;
            deadticks_q          <= deadticks_d;
            histotosend_q        <= histotosend_d;
            enable_outputs_q     <= enable_outputs_d;
            phasecounterselect_q <= phasecounterselect_d;
            phaseupdown_q        <= phaseupdown_d;
            phasestep_q          <= phasestep_d;
            scanclk_q            <= scanclk_d;
            clkswitch_q          <= clkswitch_d;
            resethist_q          <= resethist_d;
            tx_start_q           <= tx_start_d;
            tx_data_q            <= tx_data_d;
            buf_q                <= buf_d;
            tx_len_q             <= tx_len_d;
            tx_idx_q             <= tx_idx_d;
            steps_q              <= steps_d;
            div_q                <= div_d;
            tog_q                <= tog_d;
            cs_cnt_q             <= cs_cnt_d;
        end
    end

    assign uart.tx_start      = tx_start_q;
    assign uart.tx_data       = tx_data_q;
    assign last_cmd           = last_cmd_q;
    assign deadticks          = deadticks_q;
    assign histotosend        = histotosend_q;
    assign enable_outputs     = enable_outputs_q;
    assign phasecounterselect = phasecounterselect_q;
    assign phaseupdown        = phaseupdown_q;
    assign phasestep          = phasestep_q;
    assign scanclk            = scanclk_q;
    assign clkswitch          = clkswitch_q;
    assign resethist          = resethist_q;
    assign busy               = (state_q != IDLE);
    assign err_count          = err_count_q;

endmodule

// File: tb/tb_serial_cmd_engine.sv
// -----------------------------------------------------------------------------
// tb_serial_cmd_engine
// Self-checking bench for serial_cmd_engine (NHISTO=2, small timers).
// Config/short-response commands run from a vector table; histogram,
// phase, clock-switch, timeout and mid-operation reset are hand sequences.
// Transmitted bytes are checked against a queue of expected bytes.
// -----------------------------------------------------------------------------
module tb_serial_cmd_engine;
    localparam int FW      = 8'hA5;
    localparam int NH      = 2;
    localparam int HW      = 32;
    localparam int ND      = 4;
    localparam int ATO     = 20;
    localparam int SDIV    = 2;
    localparam int CSW     = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic [7:0]       last_cmd, deadticks, histotosend, err_count;
    logic             enable_outputs, phaseupdown, phasestep, scanclk, clkswitch;
    logic             resethist, activeclock, busy;
    logic [2:0]       phasecounterselect;
    logic [NH*HW-1:0] histos;
    logic [ND*8-1:0]  delaycounter;

    serial_cmd_engine_if uart_if();

    serial_cmd_engine #(
        .FW_VERSION(FW), .NHISTO(NH), .HISTO_WIDTH(HW), .NDELAY(ND),
        .ARG_TIMEOUT(ATO), .SCAN_DIV(SDIV), .CLKSWITCH_CYCLES(CSW)
    ) dut (
        .clk(clk), .reset(reset), .uart(uart_if),
        .last_cmd(last_cmd), .deadticks(deadticks), .histotosend(histotosend),
        .enable_outputs(enable_outputs), .phasecounterselect(phasecounterselect),
        .phaseupdown(phaseupdown), .phasestep(phasestep), .scanclk(scanclk),
        .clkswitch(clkswitch), .histos(histos), .resethist(resethist),
        .delaycounter(delaycounter), .activeclock(activeclock), .busy(busy),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int drive_cyc = 0;
    logic [7:0] exp_q[$];

    int tx_seen = 0, last_tx_cyc = 0, busy_cnt = 0;
    int rh_cnt = 0, rh_cyc = 0;
    int ps_rise = 0, sc_tog = 0, sc_tog_ps = 0, ps_high = 0, ph_cyc = 0, cs_high = 0;
    logic ph_arm = 1'b0, ps_prev = 1'b0, sc_prev = 1'b0;

    typedef struct {
        logic [7:0] cmd;
        int         nargs;
        logic [7:0] a0;
        logic [7:0] a1;
        logic       actclk;
        logic [7:0] exp_dt;
        logic [7:0] exp_hs;
        logic       exp_en;
        logic       exp_pud;
        int         ntx;
        logic [7:0] tx0;
    } vec_t;
    vec_t vt [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        uart_if.rx_ready = 1'b1;
        uart_if.rx_data  = b;
        drive_cyc        = cyc;
        @(negedge clk);
        uart_if.rx_ready = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((busy || exp_q.size() != 0 || uart_if.tx_busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            checks++;
            errors++;
            $display("FAIL wait_idle got busy=%0b pending=%0d required idle", busy, exp_q.size());
        end
        @(negedge clk);
    endtask

    always @(posedge clk) cyc++;

    // UART-side model and observation counters, all sampled mid-cycle.
    always @(negedge clk) begin
        if (uart_if.tx_start) begin
            if (tx_seen > 0) check("tx_spacing_ok", 32'(cyc - last_tx_cyc >= 2), 32'd1);
            tx_seen++;
            last_tx_cyc = cyc;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL tx_unexpected got %0h required none", uart_if.tx_data);
            end else begin
                check("tx_byte", 32'(uart_if.tx_data), 32'(exp_q.pop_front()));
            end
            busy_cnt = 3;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
        end
        uart_if.tx_busy = (busy_cnt != 0);
        if (resethist) begin rh_cnt++; rh_cyc = cyc; end
        if (phasestep && !ps_prev) ps_rise++;
        if (scanclk != sc_prev) begin
            sc_tog++;
            if (ps_prev) sc_tog_ps++;
        end
        if (phasestep) begin ps_high++; ph_arm = 1'b1; end
        if (ph_arm && busy) ph_cyc++;
        if (clkswitch) cs_high++;
        ps_prev = phasestep;
        sc_prev = scanclk;
    end

    initial begin
        int n;
        int seen0;
        //          cmd    na a0     a1     act   dt     hs     en    pud   ntx tx0
        vt[0] = '{8'h00, 0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1, 8'hA5};
        vt[1] = '{8'h01, 1, 8'h2A, 8'h00, 1'b0, 8'h2A, 8'h00, 1'b0, 1'b1, 0, 8'h00};
        vt[2] = '{8'h02, 1, 8'h05, 8'h00, 1'b0, 8'h2A, 8'h05, 1'b0, 1'b1, 0, 8'h00};
        vt[3] = '{8'h03, 0, 8'h00, 8'h00, 1'b0, 8'h2A, 8'h05, 1'b1, 1'b1, 0, 8'h00};
        vt[4] = '{8'h09, 0, 8'h00, 8'h00, 1'b0, 8'h2A, 8'h05, 1'b1, 1'b0, 0, 8'h00};
        vt[5] = '{8'h08, 0, 8'h00, 8'h00, 1'b0, 8'h2A, 8'h05, 1'b1, 1'b0, 1, 8'h00};
        vt[6] = '{8'h03, 0, 8'h00, 8'h00, 1'b1, 8'h2A, 8'h05, 1'b0, 1'b0, 0, 8'h00};
        vt[7] = '{8'h09, 0, 8'h00, 8'h00, 1'b1, 8'h2A, 8'h05, 1'b0, 1'b1, 0, 8'h00};
        vt[8] = '{8'h0D, 0, 8'h00, 8'h00, 1'b0, 8'h2A, 8'h05, 1'b0, 1'b1, 1, 8'h00};

        reset            = 1'b1;
        uart_if.rx_ready = 1'b0;
        uart_if.rx_data  = 8'h00;
        uart_if.tx_busy  = 1'b0;
        activeclock      = 1'b0;
        histos           = '0;
        delaycounter     = 32'hDEADBEEF;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        check("rst_tx_start", 32'(uart_if.tx_start), 32'd0);
        check("rst_tx_data", 32'(uart_if.tx_data), 32'd0);
        check("rst_outputs", {last_cmd, deadticks, histotosend, 8'(phasecounterselect)}, 32'd0);
        check("rst_bits", {26'd0, enable_outputs, phaseupdown, phasestep, scanclk, clkswitch, resethist}, 32'h10);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err_count), 32'd0);

        foreach (vt[i]) begin
            activeclock = vt[i].actclk;
            if (vt[i].ntx > 0) exp_q.push_back(vt[i].tx0);
            send_byte(vt[i].cmd);
            if (vt[i].nargs > 0) send_byte(vt[i].a0);
            if (vt[i].nargs > 1) send_byte(vt[i].a1);
            wait_idle(100);
            check("tbl_last_cmd", 32'(last_cmd), 32'(vt[i].cmd));
            check("tbl_deadticks", 32'(deadticks), 32'(vt[i].exp_dt));
            check("tbl_histotosend", 32'(histotosend), 32'(vt[i].exp_hs));
            check("tbl_enable", 32'(enable_outputs), 32'(vt[i].exp_en));
            check("tbl_phaseupdown", 32'(phaseupdown), 32'(vt[i].exp_pud));
            check("tbl_err", 32'(err_count), 32'd0);
        end

        // Histogram snapshot; inputs change once streaming has started.
        histos = {32'hAABBCCDD, 32'h11223344};
        foreach (exp_q[i]) exp_q.delete(i);
        exp_q = '{8'h44, 8'h33, 8'h22, 8'h11, 8'hDD, 8'hCC, 8'hBB, 8'hAA};
        rh_cnt = 0;
        seen0  = tx_seen;
        send_byte(8'h0A);
        n = 0;
        while (tx_seen == seen0 && n < 50) begin @(negedge clk); n++; end
        histos = '1;
        wait_idle(200);
        check("histo_tx_count", 32'(tx_seen - seen0), 32'd8);
        check("resethist_pulses", 32'(rh_cnt), 32'd1);
        check("resethist_timing", 32'(rh_cyc - drive_cyc), 32'd2);

        // Three phase steps, counter 3, direction up.
        ps_rise = 0; sc_tog = 0; sc_tog_ps = 0; ps_high = 0; ph_cyc = 0; ph_arm = 1'b0;
        send_byte(8'h05); send_byte(8'h83); send_byte(8'h03);
        wait_idle(300);
        check("ph_select", 32'(phasecounterselect), 32'd3);
        check("ph_updown", 32'(phaseupdown), 32'd1);
        check("ph_steps", 32'(ps_rise), 32'd3);
        check("ph_toggles", 32'(sc_tog), 32'd24);
        check("ph_toggles_in_step", 32'(sc_tog_ps), 32'd18);
        check("ph_step_high", 32'(ps_high), 32'(3 * 6 * SDIV));
        check("ph_total_cycles", 32'(ph_cyc), 32'(24 * SDIV));
        check("ph_scanclk_end", 32'(scanclk), 32'd0);

        // Step count 0 behaves as a single step.
        ps_rise = 0; sc_tog = 0; ph_arm = 1'b0;
        send_byte(8'h05); send_byte(8'h01); send_byte(8'h00);
        wait_idle(200);
        check("ph0_steps", 32'(ps_rise), 32'd1);
        check("ph0_toggles", 32'(sc_tog), 32'd8);
        check("ph0_select", 32'(phasecounterselect), 32'd1);
        check("ph0_updown", 32'(phaseupdown), 32'd0);

        cs_high = 0;
        send_byte(8'h04);
        wait_idle(100);
        check("clkswitch_cycles", 32'(cs_high), 32'(CSW));

        // Argument timeout, then an argument on the last allowed cycle.
        send_byte(8'h01);
        repeat (ATO + 3) @(negedge clk);
        check("to_err", 32'(err_count), 32'd1);
        check("to_busy", 32'(busy), 32'd0);
        check("to_deadticks", 32'(deadticks), 32'h2A);
        send_byte(8'h01);
        repeat (ATO - 2) @(negedge clk);
        send_byte(8'h33);
        wait_idle(100);
        check("late_arg_deadticks", 32'(deadticks), 32'h33);
        check("late_arg_err", 32'(err_count), 32'd1);

        send_byte(8'h55);
        wait_idle(100);
        check("bad_cmd_err", 32'(err_count), 32'd2);

        // Delay counter response with a byte dropped mid-stream.
        exp_q = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        seen0 = tx_seen;
        send_byte(8'h0B);
        n = 0;
        while (tx_seen == seen0 && n < 50) begin @(negedge clk); n++; end
        send_byte(8'h00);
        wait_idle(200);
        check("dly_tx_count", 32'(tx_seen - seen0), 32'd4);
        check("drop_err", 32'(err_count), 32'd3);
        exp_q.push_back(8'h03);
        send_byte(8'h0D);
        wait_idle(100);

        // Reset in the middle of a phase step.
        send_byte(8'h05); send_byte(8'h02); send_byte(8'h05);
        n = 0;
        while (!(scanclk && phasestep) && n < 100) begin @(negedge clk); n++; end
        check("mid_ph_seen", 32'(scanclk && phasestep), 32'd1);
        reset = 1'b1;
        #1;
        check("rst_ph_phasestep", 32'(phasestep), 32'd0);
        check("rst_ph_scanclk", 32'(scanclk), 32'd0);
        check("rst_ph_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Reset while a delay-counter byte is being launched.
        exp_q = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        send_byte(8'h0B);
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!uart_if.tx_start && n < 50);
        check("mid_tx_seen", 32'(uart_if.tx_start), 32'd1);
        reset = 1'b1;
        #1;
        check("rst_tx_start_mid", 32'(uart_if.tx_start), 32'd0);
        check("rst_tx_busy", 32'(busy), 32'd0);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;

        activeclock = 1'b1;
        exp_q.push_back(8'h01);
        send_byte(8'h08);
        wait_idle(100);
        check("post_rst_err", 32'(err_count), 32'd0);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_cmd_engine.md
Name: serial_cmd_engine

Overview:
- Parametrised successor to the board's byte-serial command processor. Sits between the UART rx/tx pair and the trigger fabric.
- Decodes single-byte commands with per-command argument counts and drives config registers, PLL dynamic-phase and clock-switch controls.
- Streams snapshot responses: version, active clock, histograms, delay counters, status.
- New versus the previous generation:
  - parametrised channel count and width;
  - multi-step phase commands with explicit select and direction;
  - argument-byte timeout;
  - overrun and error accounting;
  - asynchronous reset.

Parameters:
FW_VERSION, 4, byte returned by command 0
NHISTO, 8, number of histogram channels
HISTO_WIDTH, 32, bits per histogram channel (multiple of 8, 8..32)
NDELAY, 16, number of delaycounter bytes
ARG_TIMEOUT, 50000000, clk cycles allowed between argument bytes
SCAN_DIV, 16, clk cycles per scanclk half-period
CLKSWITCH_CYCLES, 8, clk cycles clkswitch is held high

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
rx_ready  in  1  one-cycle strobe, rx_data valid
rx_data  in  8  received byte
tx_busy  in  1  transmitter busy
tx_start  out  1  one-cycle strobe, tx_data valid
tx_data  out  8  byte to transmit
last_cmd  out  8  most recent command byte
deadticks  out  8  dead-time config
histotosend  out  8  histogram select config
enable_outputs  out  1  output-enable toggle (low enables outputs)
phasecounterselect  out  3  PLL counter select
phaseupdown  out  1  PLL phase direction (1 = up)
phasestep  out  1  PLL phasestep
scanclk  out  1  PLL scan clock
clkswitch  out  1  PLL clock-switch request
histos  in  NHISTO*HISTO_WIDTH  histogram counts; channel k at [k*HISTO_WIDTH +: HISTO_WIDTH]
resethist  out  1  one-cycle histogram clear
delaycounter  in  NDELAY*8  delay bytes; byte k at [8k +: 8]
activeclock  in  1  PLL active-clock indicator
busy  out  1  high in any state other than IDLE
err_count  out  8  saturating error counter

Behaviour:
- Single clock clk. reset asynchronous, active-high.
- Reset values:
  - all outputs 0, except phaseupdown = 1;
  - state IDLE, err_count = 0.
- Reset mid-operation aborts immediately. Stalls any transmission and phase step in progress.
- States: IDLE, ARGS, EXEC, TX_WAIT, TX_HOLD, PHASE, CLKSW.
- IDLE: on rx_ready, latch rx_data into last_cmd. Go to ARGS if the command needs arguments, else EXEC.
- ARGS:
  - Collect the required bytes into an argument buffer.
  - A timer resets on each byte.
  - Timer reaching ARG_TIMEOUT: discard the command, err_count += 1, go to IDLE.
- EXEC (one cycle), by command:
  - 0: respond FW_VERSION (1 byte).
  - 1: 1 arg; deadticks = arg0.
  - 2: 1 arg; histotosend = arg0.
  - 3: enable_outputs inverts.
  - 4: go to CLKSW.
  - 5: 2 args.
    - phasecounterselect = arg0[2:0]; phaseupdown = arg0[7].
    - Step count N = arg1; N = 0 is treated as 1.
    - Go to PHASE.
  - 8: respond {7'b0, activeclock}.
  - 9: phaseupdown inverts.
  - 10: snapshot all histos this cycle.
    - Response is NHISTO*HISTO_WIDTH/8 bytes, channel 0 first, least significant byte first within a channel.
    - resethist pulses high for exactly one cycle, the cycle after the snapshot.
  - 11: snapshot delaycounter; respond NDELAY bytes, byte 0 first.
  - 13: respond err_count (1 byte).
  - Any other value: err_count += 1, go to IDLE.
- Response path:
  - The snapshot is held in an internal buffer of depth max(NHISTO*HISTO_WIDTH/8, NDELAY).
  - TX_WAIT: when tx_busy = 0, drive tx_data and pulse tx_start for one cycle, then go to TX_HOLD.
  - TX_HOLD: hold one cycle, then continue the next byte in TX_WAIT or go to IDLE after the last byte.
  - Minimum spacing between tx_start pulses is 2 cycles.
  - tx_data is stable from the tx_start cycle until the next tx_start.
- PHASE, per step:
  - phasestep = 1 and scanclk = 0 at step start.
  - scanclk toggles every SCAN_DIV cycles.
  - phasestep drops after the 6th toggle; the step ends after the 8th toggle.
  - Repeat N steps, then go to IDLE.
  - scanclk returns to 0 at the end of every step.
- CLKSW: clkswitch is high for exactly CLKSWITCH_CYCLES cycles, then go to IDLE.
- rx_ready in EXEC, TX_WAIT, TX_HOLD, PHASE or CLKSW: byte dropped, err_count += 1.
- err_count saturates at 255. Command 13 does not clear it.

Test Plan:
- Reset, then rx 0x00 → one tx_start with tx_data = FW_VERSION; outputs at reset values; busy returns to 0.
- rx 0x01, 0x2A, then 0x02, 0x05 → deadticks = 0x2A, histotosend = 0x05; no tx_start.
- histos channel 0 = 0x11223344, channel 1 = 0xAABBCCDD (NHISTO = 2); rx 0x0A → tx bytes 44,33,22,11,DD,CC,BB,AA; resethist pulses once, one cycle after EXEC. Change histos mid-stream → transmitted bytes unchanged.
- rx 0x05, 0x83, 0x03 → phasecounterselect = 3, phaseupdown = 1, three phasestep pulses each spanning 6 scanclk toggles; 8 toggles per step; total 24*SCAN_DIV cycles.
- rx 0x01 followed by ARG_TIMEOUT idle cycles → no deadticks change, err_count = 1. rx 0x55 → err_count = 2. rx 0x0D → tx_data = 0x02.
- Assert reset during a PHASE step and during a 0x0B response → phasestep, scanclk and tx_start go to 0 immediately; after release, rx 0x08 with activeclock = 1 → tx_data = 0x01.
